// File: rtl/hex_display_reader.sv
// Reads back the six active-low seven-segment buses, decodes each to a hex
// nibble and publishes a frame once all 48 bits have been stable long enough.
module hex_display_reader #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        ADC_CLK_10,
  input  logic        Rn,
  input  logic [7:0]  HEX0,
  input  logic [7:0]  HEX1,
  input  logic [7:0]  HEX2,
  input  logic [7:0]  HEX3,
  input  logic [7:0]  HEX4,
  input  logic [7:0]  HEX5,
  output logic [23:0] value,
  output logic [5:0]  blank,
  output logic [5:0]  dp,
  output logic [5:0]  invalid,
  output logic        valid,
  output logic [7:0]  err_count
);

  localparam logic [7:0] C_THRESH = 8'(STABLE_CYCLES - 1);

  typedef enum logic {SETTLE, LOCKED} state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [47:0] r_samp;
  logic [47:0] r_pub;
  logic [7:0]  r_cnt;
  logic        r_first;
  logic [23:0] r_value;
  logic [5:0]  r_blank;
  logic [5:0]  r_dp;
  logic [5:0]  r_invalid;
  logic        r_valid;
  logic [7:0]  r_errCount;

  logic [47:0] w_frame;
  logic        w_match;
  logic        w_publish;
  logic [23:0] w_value;
  logic [5:0]  w_blank;
  logic [5:0]  w_dp;
  logic [5:0]  w_invalid;

  // Returns {invalid, blank, nibble}; unknown glyphs and blanks read as 0.
  function automatic logic [5:0] decodeGlyph(input logic [6:0] seg);
    case (seg)
      7'h40: decodeGlyph = 6'h00;
      7'h79: decodeGlyph = 6'h01;
      7'h24: decodeGlyph = 6'h02;
      7'h30: decodeGlyph = 6'h03;
      7'h19: decodeGlyph = 6'h04;
      7'h12: decodeGlyph = 6'h05;
      7'h02: decodeGlyph = 6'h06;
      7'h78: decodeGlyph = 6'h07;
      7'h00: decodeGlyph = 6'h08;
      7'h10: decodeGlyph = 6'h09;
      7'h08: decodeGlyph = 6'h0A;
      7'h03: decodeGlyph = 6'h0B;
      7'h46: decodeGlyph = 6'h0C;
      7'h21: decodeGlyph = 6'h0D;
      7'h06: decodeGlyph = 6'h0E;
      7'h0E: decodeGlyph = 6'h0F;
      7'h7F: decodeGlyph = 6'h10;
      default: decodeGlyph = 6'h20;
    endcase
  endfunction

  assign w_frame = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
  assign w_match = (w_frame == r_samp);

  always_comb begin
    logic [5:0] dec;
    w_value   = '0;
    w_blank   = '0;
    w_dp      = '0;
    w_invalid = '0;
    for (int n = 0; n < 6; n++) begin
      dec             = decodeGlyph(w_frame[n*8 +: 7]);
      w_value[n*4 +: 4] = dec[3:0];
      w_blank[n]      = dec[4];
      w_invalid[n]    = dec[5];
      w_dp[n]         = ~w_frame[n*8 + 7];
    end
  end

  // A stable frame identical to the last published one locks silently.
  always_comb begin
    w_nextState = r_state;
    w_publish   = 1'b0;
    case (r_state)
      SETTLE: begin
        if (w_match && (r_cnt == C_THRESH)) begin
          w_nextState = LOCKED;
          w_publish   = r_first || (w_frame != r_pub);
        end
      end
      LOCKED: begin
        if (!w_match) w_nextState = SETTLE;
      end
      default: w_nextState = SETTLE;
    endcase
  end

  always_ff @(posedge ADC_CLK_10 or negedge Rn) begin
    if (!Rn) begin
      r_state    <= SETTLE;
      r_samp     <= '0;
      r_pub      <= '0;
      r_cnt      <= '0;
      r_first    <= 1'b1;
      r_value    <= '0;
      r_blank    <= '0;
      r_dp       <= '0;
      r_invalid  <= '0;
      r_valid    <= 1'b0;
      r_errCount <= '0;
    end else begin
      r_state <= w_nextState;
      r_samp  <= w_frame;
      r_valid <= w_publish;
      if (!w_match)            r_cnt <= '0;
      else if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
      if (w_publish) begin
        r_value   <= w_value;
        r_blank   <= w_blank;
        r_dp      <= w_dp;
        r_invalid <= w_invalid;
        r_pub     <= w_frame;
        r_first   <= 1'b0;
        if ((|w_invalid) && (r_errCount != 8'hFF)) r_errCount <= r_errCount + 8'd1;
      end
    end
  end

  assign value     = r_value;
  assign blank     = r_blank;
  assign dp        = r_dp;
  assign invalid   = r_invalid;
  assign valid     = r_valid;
  assign err_count = r_errCount;

endmodule

// File: doc/hex_display_reader.md
# hex_display_reader

Recovers the digits shown on the board's six seven-segment displays by reading back the HEX0–HEX5 segment buses that the display encoder drives. It decodes each active-low segment byte to a hex nibble, waits until all six buses have been stable for a programmable number of cycles, and publishes the frame with a one-cycle valid strobe. It sits beside the Lab3 top level in the ADC_CLK_10 domain as an on-board self-check and bench scoreboard front end.

## Interface
- STABLE_CYCLES, 4: consecutive matching edges required before a frame is published.
  - Legal range 1..255.
  - Counter is 8 bits wide.
- ADC_CLK_10 input 1: the single clock. All logic is rising-edge.
- Rn input 1: reset, asynchronous, active-low.
- HEX0..HEX5 input 8 each: segment buses, active-low.
  - Bits [6:0] are segments a..g.
  - Bit [7] is the decimal point.
- value output 24: published digits. Nibble n is HEXn, so value[3:0] = HEX0.
- blank output 6: bit n set when HEXn[6:0] = 7'h7F (all segments off).
- dp output 6: bit n = ~HEXn[7] of the published frame.
- invalid output 6: bit n set when HEXn[6:0] is not a recognised glyph.
- valid output 1: one-cycle pulse when a new frame is published.
- err_count output 8: saturating count of published frames with any invalid bit set.

## Operation
- Glyph table (HEXn[6:0] -> nibble):
  - 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7
  - 00->8, 10->9, 08->A, 03->b, 46->C, 21->d, 06->E, 0E->F
  - 7F -> nibble 0 with blank set.
  - Any other pattern -> nibble 0 with invalid set.
- Decoding uses bits [6:0] only.
- Stability check covers all 48 input bits, so a dp change alone counts as a pattern change.
- samp (48 bits) is loaded from the concatenated HEX buses every edge.
- match = (HEX inputs == samp).
- cnt updates every edge: cnt <= match ? min(cnt+1, 255) : 0.
- State machine:
  - SETTLE: on match with cnt == STABLE_CYCLES-1, the frame is stable.
    - If the frame differs from the last published pattern pub, or no frame has been published since reset (first flag set): register value/blank/dp/invalid, pulse valid, load pub, clear first, update err_count, go to LOCKED.
    - Otherwise go to LOCKED with no outputs changed and no valid pulse.
  - LOCKED: on any mismatch, go to SETTLE. Otherwise hold.
- A glitch shorter than STABLE_CYCLES never publishes.
- A pattern that returns to the published frame after a glitch does not re-publish.
- err_count increments on a publish with |invalid set, and saturates at 255.
- value/blank/dp/invalid change only on a publish.

## Timing
- Reset values:
  - value = 0, blank = 0, dp = 0, invalid = 0, valid = 0, err_count = 0.
  - cnt = 0, samp = 0, pub = 0, state = SETTLE, first = 1.
- Reset is asynchronous. Outputs clear immediately when Rn falls, including mid-settle or while valid is high.
- After Rn rises, the first stable frame is always published, even if identical to the frame published before reset.
- Latency: let E0 be the first edge at which a new pattern is present on the inputs.
  - Outputs update and valid is high after edge E(STABLE_CYCLES), i.e. STABLE_CYCLES+1 edges counting E0.
  - STABLE_CYCLES = 4: valid is high in the cycle after the 5th edge.
  - STABLE_CYCLES = 1: valid follows the 2nd edge.
- valid is high for exactly one cycle per publish. It is never high on consecutive cycles.
- A mismatch on the same edge that cnt would reach the threshold resets cnt to 0, and no publish occurs.

## Test plan
1. Defaults; release Rn; hold HEX0..HEX5 = C0, F9, A4, B0, 99, 92 -> single valid pulse after 5th edge; value = 24'h543210; blank = 0, invalid = 0, dp = 0; err_count = 0.
2. From test 1, drive HEX0 = F9 for 2 cycles, then back to C0 -> no valid pulse; value stays 24'h543210. Then hold HEX0 = F9 -> valid after 5 edges; value = 24'h543211.
3. HEX5 = FF, HEX4 = 7F, HEX3..HEX1 = 88, 83, C6, HEX0 = 8E -> value = 24'h00ABCF; blank = 6'b110000; dp = 6'b010000; invalid = 0.
4. HEX2 = AA, others = C0 -> invalid = 6'b000100; value[11:8] = 0; err_count = 1. Re-publish a different frame that keeps HEX2 = AA (change HEX0 to F9) -> err_count = 2.
5. Rn pulsed low when cnt = 2 during settle -> all outputs 0 immediately. After release, the same pattern is held -> published 5 edges later with valid = 1.
6. STABLE_CYCLES = 1, inputs toggling between two valid frames every 2 cycles -> one valid pulse per frame change; valid is never asserted on adjacent cycles.
